// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer and the MIPS datapath:
// IR fields and status flags in, mux selects and write strobes out.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       trap;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output pc_write, pc_src, iord, mem_req, mem_we, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state, trap
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  pc_write, pc_src, iord, mem_req, mem_we, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state, trap
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory
// port with a req/ready handshake and a latency watchdog that traps.
module multicycle_control #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [5:0]         op_q;
    logic [5:0]         fn_q;
    logic               timed_out;

    function automatic logic funct_legal(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: funct_legal = 1'b1;
            default:                                       funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R:                                                     instr_legal = funct_legal(fn);
            OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW:     instr_legal = 1'b1;
            default:                                                  instr_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            6'h22:   r_alu_op = ALU_SUB;
            6'h24:   r_alu_op = ALU_AND;
            6'h25:   r_alu_op = ALU_OR;
            6'h2A:   r_alu_op = ALU_SLT;
            6'h00:   r_alu_op = ALU_SLL;
            6'h02:   r_alu_op = ALU_SRL;
            default: r_alu_op = ALU_ADD;
        endcase
    endfunction

    assign timed_out = (wait_cnt == WAIT_LIMIT) && !bus.mem_ready;

    // Any state change clears the watchdog, so it always starts at 0 on entry to FETCH/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
            fn_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if ((state_q == FETCH || state_q == MEM) && !bus.mem_ready
                         && wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_q == DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH: begin
                if (bus.mem_ready)  state_d = DECODE;
                else if (timed_out) state_d = TRAP;
            end
            DECODE: state_d = instr_legal(bus.opcode, bus.funct) ? EXEC : TRAP;
            EXEC: begin
                case (op_q)
                    OP_R, OP_ADDI, OP_ANDI, OP_ORI: state_d = WB;
                    OP_LW, OP_SW:                   state_d = MEM;
                    OP_BEQ, OP_J:                   state_d = FETCH;
                    default:                        state_d = TRAP;
                endcase
            end
            MEM: begin
                if (bus.mem_ready)  state_d = (op_q == OP_LW) ? WB : FETCH;
                else if (timed_out) state_d = TRAP;
            end
            WB:     state_d = FETCH;
            TRAP:   state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.iord       = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 3'd0;
        bus.alu_op     = ALU_ADD;
        bus.trap       = 1'b0;
        bus.state      = state_q;
        case (state_q)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 3'd3;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b = 3'd4;
            end
            EXEC: begin
                case (op_q)
                    OP_R: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_op    = r_alu_op(fn_q);
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 3'd1;
                    end
                    OP_ANDI: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 3'd2;
                        bus.alu_op    = ALU_AND;
                    end
                    OP_ORI: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 3'd2;
                        bus.alu_op    = ALU_OR;
                    end
                    OP_BEQ: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_op    = ALU_SUB;
                        bus.pc_src    = 2'd1;
                        bus.pc_write  = bus.alu_zero;
                    end
                    OP_J: begin
                        bus.pc_src   = 2'd2;
                        bus.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = (op_q == OP_SW);
            end
            WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = (op_q == OP_R);
                bus.mem_to_reg = (op_q == OP_LW);
            end
            TRAP: begin
                bus.trap = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues its
// expected control word, a negedge monitor pops and compares it.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] state;
        logic       trap;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
    } ctl_t;

    localparam logic [5:0] G = 6'h3F;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    ctl_t  exp_q[$];
    string name_q[$];
    ctl_t  mon_exp;
    string mon_name;

    multicycle_control_if bus ();

    multicycle_control #(.MAX_WAIT(15), .WAIT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t e_idle();
        ctl_t e = '0;
        return e;
    endfunction

    function automatic ctl_t e_fetch(input logic rdy);
        ctl_t e = '0;
        e.state = 3'd1; e.mem_req = 1'b1; e.alu_src_b = 3'd3;
        e.pc_write = rdy; e.ir_write = rdy;
        return e;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t e = '0;
        e.state = 3'd2; e.alu_src_b = 3'd4;
        return e;
    endfunction

    function automatic ctl_t e_exec_alu(input logic [2:0] srcb, input logic [2:0] op);
        ctl_t e = '0;
        e.state = 3'd3; e.alu_src_a = 1'b1; e.alu_src_b = srcb; e.alu_op = op;
        return e;
    endfunction

    function automatic ctl_t e_exec_beq(input logic z);
        ctl_t e = '0;
        e.state = 3'd3; e.alu_src_a = 1'b1; e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_write = z;
        return e;
    endfunction

    function automatic ctl_t e_exec_j();
        ctl_t e = '0;
        e.state = 3'd3; e.pc_src = 2'd2; e.pc_write = 1'b1;
        return e;
    endfunction

    function automatic ctl_t e_mem(input logic we);
        ctl_t e = '0;
        e.state = 3'd4; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = we;
        return e;
    endfunction

    function automatic ctl_t e_wb(input logic dst, input logic m2r);
        ctl_t e = '0;
        e.state = 3'd5; e.reg_write = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r;
        return e;
    endfunction

    function automatic ctl_t e_trap();
        ctl_t e = '0;
        e.state = 3'd7; e.trap = 1'b1;
        return e;
    endfunction

    function automatic ctl_t sample();
        ctl_t a;
        a.state = bus.state; a.trap = bus.trap; a.pc_write = bus.pc_write;
        a.pc_src = bus.pc_src; a.iord = bus.iord; a.mem_req = bus.mem_req;
        a.mem_we = bus.mem_we; a.ir_write = bus.ir_write; a.reg_write = bus.reg_write;
        a.reg_dst = bus.reg_dst; a.mem_to_reg = bus.mem_to_reg;
        a.alu_src_a = bus.alu_src_a; a.alu_src_b = bus.alu_src_b; a.alu_op = bus.alu_op;
        return a;
    endfunction

    task automatic checkOutput(input ctl_t exp, input string name);
        ctl_t act;
        act = sample();
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                     name, act.state, act, exp.state, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the control word expected during that cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic rdy, input logic z,
                                 input ctl_t exp, input string name);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        bus.alu_zero  = z;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checkOutput(mon_exp, mon_name);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(G, G, 1'b1, 1'b1, e_idle(), "reset_hold");
        rst_n = 1'b1;
        applyStimulus(G, G, 1'b1, 1'b1, e_idle(), "reset_release");
    endtask

    task automatic run_r(input logic [5:0] fn, input logic [2:0] op, input string nm);
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), {nm, "_fetch"});
        applyStimulus(6'h00, fn, 1'b1, 1'b0, e_decode(), {nm, "_decode"});
        applyStimulus(G, G, 1'b1, 1'b1, e_exec_alu(3'd0, op), {nm, "_exec"});
        applyStimulus(G, G, 1'b1, 1'b0, e_wb(1'b1, 1'b0), {nm, "_wb"});
    endtask

    task automatic run_i(input logic [5:0] opc, input logic [2:0] srcb,
                         input logic [2:0] op, input string nm);
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), {nm, "_fetch"});
        applyStimulus(opc, G, 1'b1, 1'b0, e_decode(), {nm, "_decode"});
        applyStimulus(G, G, 1'b1, 1'b0, e_exec_alu(srcb, op), {nm, "_exec"});
        applyStimulus(G, G, 1'b1, 1'b0, e_wb(1'b0, 1'b0), {nm, "_wb"});
    endtask

    task automatic run_beq(input logic z, input string nm);
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), {nm, "_fetch"});
        applyStimulus(6'h04, G, 1'b1, 1'b0, e_decode(), {nm, "_decode"});
        applyStimulus(G, G, 1'b1, z, e_exec_beq(z), {nm, "_exec"});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // R-type alu_op mapping, one instruction per funct
        run_r(6'h20, 3'd0, "add");
        run_r(6'h22, 3'd1, "sub");
        run_r(6'h24, 3'd2, "and");
        run_r(6'h25, 3'd3, "or");
        run_r(6'h2A, 3'd4, "slt");
        run_r(6'h00, 3'd5, "sll");
        run_r(6'h02, 3'd6, "srl");

        run_i(6'h08, 3'd1, 3'd0, "addi");
        run_i(6'h0C, 3'd2, 3'd2, "andi");
        run_i(6'h0D, 3'd2, 3'd3, "ori");

        // lw with two memory wait cycles: 7 cycles total
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
        applyStimulus(6'h23, G, 1'b1, 1'b0, e_decode(), "lw_decode");
        applyStimulus(G, G, 1'b1, 1'b0, e_exec_alu(3'd1, 3'd0), "lw_exec");
        applyStimulus(G, G, 1'b0, 1'b0, e_mem(1'b0), "lw_mem_wait1");
        applyStimulus(G, G, 1'b0, 1'b0, e_mem(1'b0), "lw_mem_wait2");
        applyStimulus(G, G, 1'b1, 1'b0, e_mem(1'b0), "lw_mem_done");
        applyStimulus(G, G, 1'b1, 1'b0, e_wb(1'b0, 1'b1), "lw_wb");

        run_beq(1'b1, "beq_taken");
        run_beq(1'b0, "beq_not_taken");

        // sw with one fetch wait, then j
        applyStimulus(G, G, 1'b0, 1'b0, e_fetch(1'b0), "sw_fetch_wait");
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
        applyStimulus(6'h2B, G, 1'b1, 1'b0, e_decode(), "sw_decode");
        applyStimulus(G, G, 1'b1, 1'b0, e_exec_alu(3'd1, 3'd0), "sw_exec");
        applyStimulus(G, G, 1'b1, 1'b0, e_mem(1'b1), "sw_mem");
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), "j_fetch");
        applyStimulus(6'h02, G, 1'b1, 1'b0, e_decode(), "j_decode");
        applyStimulus(G, G, 1'b1, 1'b0, e_exec_j(), "j_exec");

        // illegal opcode
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), "badop_fetch");
        applyStimulus(6'h3F, 6'h20, 1'b1, 1'b0, e_decode(), "badop_decode");
        applyStimulus(6'h00, 6'h20, 1'b1, 1'b1, e_trap(), "badop_trap1");
        applyStimulus(6'h23, 6'h20, 1'b0, 1'b0, e_trap(), "badop_trap2");
        applyStimulus(G, G, 1'b1, 1'b0, e_trap(), "badop_trap3");
        do_reset();

        // illegal R-type funct
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), "badfn_fetch");
        applyStimulus(6'h00, 6'h3F, 1'b1, 1'b0, e_decode(), "badfn_decode");
        applyStimulus(G, G, 1'b1, 1'b0, e_trap(), "badfn_trap1");
        applyStimulus(G, G, 1'b1, 1'b0, e_trap(), "badfn_trap2");
        do_reset();

        // ready arriving when the watchdog is at its limit still wins
        for (int i = 0; i < 15; i++)
            applyStimulus(G, G, 1'b0, 1'b0, e_fetch(1'b0), "limit_fetch_wait");
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), "limit_fetch_ready");
        applyStimulus(6'h02, G, 1'b1, 1'b0, e_decode(), "limit_decode");
        applyStimulus(G, G, 1'b1, 1'b0, e_exec_j(), "limit_exec");

        // 16 stalled fetch cycles, then the watchdog traps
        for (int i = 0; i < 16; i++)
            applyStimulus(G, G, 1'b0, 1'b0, e_fetch(1'b0), "timeout_fetch");
        applyStimulus(G, G, 1'b1, 1'b0, e_trap(), "timeout_trap1");
        applyStimulus(G, G, 1'b1, 1'b0, e_trap(), "timeout_trap2");
        do_reset();

        // reset in the middle of a stalled fetch drops the request at once
        for (int i = 0; i < 5; i++)
            applyStimulus(G, G, 1'b0, 1'b0, e_fetch(1'b0), "midstall_fetch");
        do_reset();
        applyStimulus(G, G, 1'b1, 1'b0, e_fetch(1'b1), "restart_fetch");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
